// File: rtl/psg_writer_if.sv
// Command request channel into the PSG writer: valid/ready handshake carrying one
// register update (channel, type, value).
interface psg_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_chan;
  logic       req_type;
  logic [9:0] req_data;

  modport master (
    output req_valid,
    output req_chan,
    output req_type,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_chan,
    input  req_type,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/psg_writer.sv
// Queues PSG register-update commands, encodes them as SN76489 latch/data bytes and
// drives databus/we_l with setup, strobe and hold phases for the PSG sampler.
module psg_writer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WE_CYCLES    = 1,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  psg_writer_if.slave      req,
  input  logic             audio_en,
  output logic [7:0]       databus,
  output logic             we_l,
  output logic             oe_l,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0] SetupLoad = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WeLoad    = 8'(WE_CYCLES - 1);
  localparam logic [7:0] HoldLoad  = 8'(HOLD_CYCLES - 1);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  // FIFO entry layout: {chan[1:0], type, data[9:0]}
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q;
  logic          push, pop, fifo_empty;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    bus_q, bus_d;
  logic [7:0]    second_byte_q, second_byte_d;
  logic          second_q, second_d;
  logic          we_q, we_d;
  logic          oe_q;
  logic          busy_q;

  logic [1:0]    head_chan;
  logic          head_type;
  logic [9:0]    head_data;
  logic [3:0]    head_low;
  logic [7:0]    head_latch;
  logic          head_two_byte;

  assign push       = req.req_valid && ready_q;
  assign fifo_empty = (count_q == '0);

  assign req.req_ready = ready_q;
  assign databus       = bus_q;
  assign we_l          = we_q;
  assign oe_l          = oe_q;
  assign busy          = busy_q;

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {req.req_chan, req.req_type, req.req_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FullCount);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Encode the command at the FIFO head.
  always_comb begin
    {head_chan, head_type, head_data} = mem_q[rptr_q];
    head_two_byte = !head_type && (head_chan != 2'd3);
    if (!head_type && (head_chan == 2'd3)) begin
      head_low = {1'b0, head_data[2:0]};
    end else begin
      head_low = head_data[3:0];
    end
    head_latch = {1'b1, head_chan, head_type, head_low};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_d         = bus_q;
    second_byte_d = second_byte_q;
    second_d      = second_q;
    we_d          = we_q;
    pop           = 1'b0;

    unique case (state_q)
      StIdle: begin
        we_d = 1'b1;
        if (!fifo_empty) begin
          pop           = 1'b1;
          bus_d         = head_latch;
          second_d      = head_two_byte;
          second_byte_d = {2'b00, head_data[9:4]};
          cnt_d         = SetupLoad;
          state_d       = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == 8'd0) begin
          we_d    = 1'b0;
          cnt_d   = WeLoad;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 8'd0) begin
          we_d    = 1'b1;
          cnt_d   = HoldLoad;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (second_q) begin
          bus_d    = second_byte_q;
          second_d = 1'b0;
          cnt_d    = SetupLoad;
          state_d  = StSetup;
        end else if (!fifo_empty) begin
          // Chain straight into the next command without passing through idle.
          pop           = 1'b1;
          bus_d         = head_latch;
          second_d      = head_two_byte;
          second_byte_d = {2'b00, head_data[9:4]};
          cnt_d         = SetupLoad;
          state_d       = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      bus_q         <= 8'h00;
      second_byte_q <= 8'h00;
      second_q      <= 1'b0;
      we_q          <= 1'b1;
      oe_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_q         <= bus_d;
      second_byte_q <= second_byte_d;
      second_q      <= second_d;
      we_q          <= we_d;
      oe_q          <= ~audio_en;
      busy_q        <= (state_d != StIdle) || (count_d != '0);
    end
  end

endmodule

// File: tb/tb_psg_writer.sv
// Self-checking bench for psg_writer: scoreboard of expected PSG bytes, popped on
// each falling edge of we_l, plus direct timing checks around single commands.
module tb_psg_writer;
  logic       clk;
  logic       rst;
  logic       audio_en;
  logic [7:0] databus;
  logic       we_l;
  logic       oe_l;
  logic       busy;

  psg_writer_if bus_if ();

  psg_writer #(
    .DEPTH        (4),
    .SETUP_CYCLES (1),
    .WE_CYCLES    (1),
    .HOLD_CYCLES  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus_if),
    .audio_en (audio_en),
    .databus  (databus),
    .we_l     (we_l),
    .oe_l     (oe_l),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference encoding of one command into the expected byte sequence.
  task automatic expect_cmd(input logic [1:0] c, input logic t, input logic [9:0] d);
    logic [7:0] b;
    logic [9:0] hi;
    b = 8'h80 | (8'(c) << 5) | (t ? 8'h10 : 8'h00);
    if (!t && c == 2'd3) b = b | 8'(d & 10'h007);
    else                 b = b | 8'(d & 10'h00F);
    exp_q.push_back(b);
    if (!t && c != 2'd3) begin
      hi = d >> 4;
      exp_q.push_back(8'(hi));
    end
  endtask

  // Monitor: checks each strobed byte against the scoreboard, strobe width and
  // databus stability through strobe and hold.
  initial begin
    logic       prev_we;
    logic [7:0] strobe_byte;
    int         low_len;
    prev_we     = 1'b1;
    strobe_byte = 8'h00;
    low_len     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_we = 1'b1;
        low_len = 0;
      end else begin
        if (!we_l && prev_we) begin
          strobe_byte = databus;
          strobe_cyc.push_back(cyc);
          low_len = 1;
          if (exp_q.size() == 0) check("sb_extra_strobe", exp_q.size(), 1);
          else check("sb_byte", databus, exp_q.pop_front());
        end else if (!we_l) begin
          low_len++;
        end
        if (!prev_we) begin
          check("bus_stable", databus, strobe_byte);
          if (we_l) check("we_width", low_len, 1);
        end
        prev_we = we_l;
      end
    end
  end

  // Called at #1 after a posedge; returns #1 after the edge that pushed.
  task automatic send(input logic [1:0] c, input logic t, input logic [9:0] d);
    int n;
    n = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_chan  = c;
    bus_if.req_type  = t;
    bus_if.req_data  = d;
    while (!bus_if.req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("ready_wait", bus_if.req_ready, 1);
    expect_cmd(c, t, d);
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_gaps(input string tag, input int want_n);
    check({tag, "_count"}, strobe_cyc.size(), want_n);
    for (int i = 1; i < strobe_cyc.size(); i++) begin
      check({tag, "_gap"}, strobe_cyc[i] - strobe_cyc[i-1], 3);
    end
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    audio_en         = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_chan  = 2'd0;
    bus_if.req_type  = 1'b0;
    bus_if.req_data  = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_databus", databus, 8'h00);
    check("rst_we_l", we_l, 1);
    check("rst_oe_l", oe_l, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", bus_if.req_ready, 1);

    // 1: volume chan1 = 5 -> single byte 0xB5, exact phase timing
    send(2'd1, 1'b1, 10'h005);
    bus_if.req_valid = 1'b0;
    negs(1);
    check("t1_busy_e0", busy, 1);
    check("t1_we_e0", we_l, 1);
    negs(1);
    check("t1_setup_bus", databus, 8'hB5);
    check("t1_setup_we", we_l, 1);
    negs(1);
    check("t1_strobe_we", we_l, 0);
    check("t1_strobe_bus", databus, 8'hB5);
    negs(1);
    check("t1_hold_we", we_l, 1);
    check("t1_hold_bus", databus, 8'hB5);
    negs(1);
    check("t1_busy_end", busy, 0);
    wait_idle();

    // 2: tone chan0 = 0x3FE -> 0x8E then 0x3F, six cycles
    strobe_cyc.delete();
    send(2'd0, 1'b0, 10'h3FE);
    bus_if.req_valid = 1'b0;
    negs(7);
    check("t2_busy_last", busy, 1);
    negs(1);
    check("t2_busy_drop", busy, 0);
    check_gaps("t2", 2);
    wait_idle();

    // 3: noise chan3 = 0x3FD -> 0xE5 only
    strobe_cyc.delete();
    send(2'd3, 1'b0, 10'h3FD);
    bus_if.req_valid = 1'b0;
    wait_idle();
    check("t3_count", strobe_cyc.size(), 1);

    // 4: six back-to-back volume commands fill the FIFO
    strobe_cyc.delete();
    for (int i = 0; i < 6; i++) send(2'd0, 1'b1, 10'(i));
    check("t4_full_ready", bus_if.req_ready, 0);
    bus_if.req_valid = 1'b0;
    wait_idle();
    check("t4_ready_back", bus_if.req_ready, 1);
    check_gaps("t4", 6);

    // 5: reset while strobing the tone latch byte drops the pending data byte
    send(2'd0, 1'b0, 10'h3FE);
    bus_if.req_valid = 1'b0;
    n = 0;
    while (we_l && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_saw_strobe", we_l, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_we", we_l, 1);
    check("t5_rst_bus", databus, 8'h00);
    check("t5_rst_busy", busy, 0);
    exp_q.delete();
    negs(2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    strobe_cyc.delete();
    send(2'd2, 1'b1, 10'h00F);
    bus_if.req_valid = 1'b0;
    wait_idle();
    check("t5_count", strobe_cyc.size(), 1);

    // 6: audio_en toggles mid-command only move oe_l, one cycle late
    strobe_cyc.delete();
    send(2'd1, 1'b0, 10'h2A5);
    send(2'd2, 1'b1, 10'h003);
    bus_if.req_valid = 1'b0;
    audio_en = 1'b1;
    @(negedge clk);
    check("t6_oe_lag_rise", oe_l, 1);
    @(posedge clk);
    #1;
    check("t6_oe_on", oe_l, 0);
    audio_en = 1'b0;
    @(negedge clk);
    check("t6_oe_lag_fall", oe_l, 0);
    @(posedge clk);
    #1;
    check("t6_oe_off", oe_l, 1);
    wait_idle();
    check_gaps("t6", 3);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
endmodule
